// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline: word/register types, EX/MEM FSM states
// and the captured EX/MEM bundle with its bubble value.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } exmem_state_t;

    typedef struct packed {
        logic     dre;
        logic     dwe;
        logic     memtoreg;
        logic     wen;
        logic     halt;
        regbits_t wsel;
        word_t    aluout;
        word_t    rdat2;
        word_t    instr;
    } exmem_bundle_t;

    localparam exmem_bundle_t EXMEM_NOP = '0;

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM stage signal bundle. Forwarding outputs exist only when
// EX_MEM_FWD_EN is defined.
interface ex_mem_if;
    import cpu_types_pkg::*;

    logic     exW, exFLUSH;
    logic     excuDRE, excuDWE, excuHALT, exMemToReg, exWEN;
    regbits_t exwsel;
    word_t    exaluout, exrdat2, exinstr;
    logic     dhit;
    word_t    dmemload;
    logic     dmemREN, dmemWEN;
    word_t    dmemaddr, dmemstore;
    logic     memstall, memready;
    logic     memMemToReg, memWEN, memHALT;
    regbits_t memwsel;
    word_t    memaluout, memload, meminstr;
`ifdef EX_MEM_FWD_EN
    logic     memfwd_en;
    regbits_t memfwd_sel;
    word_t    memfwd_data;
`endif

    modport exmem (
        input  exW, exFLUSH, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN,
        input  exwsel, exaluout, exrdat2, exinstr, dhit, dmemload,
`ifdef EX_MEM_FWD_EN
        output memfwd_en, memfwd_sel, memfwd_data,
`endif
        output dmemREN, dmemWEN, dmemaddr, dmemstore, memstall, memready,
        output memMemToReg, memWEN, memHALT, memwsel, memaluout, memload, meminstr
    );

    modport tb (
        output exW, exFLUSH, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN,
        output exwsel, exaluout, exrdat2, exinstr, dhit, dmemload,
`ifdef EX_MEM_FWD_EN
        input  memfwd_en, memfwd_sel, memfwd_data,
`endif
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, memstall, memready,
        input  memMemToReg, memWEN, memHALT, memwsel, memaluout, memload, meminstr
    );

endinterface

// File: rtl/ex_mem_stage_dmem_req_fsm.sv
// Data-cache request sequencer: IDLE/ACCESS state, request outputs held
// until dhit, load-data buffer, and stall/ready status.
module dmem_req_fsm
    import cpu_types_pkg::*;
#(
    parameter int ADDR_LSB = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  logic  req_dre,
    input  logic  req_dwe,
    input  word_t req_addr,
    input  word_t req_store,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output word_t memload,
    output logic  memstall,
    output logic  memready
);

    localparam word_t ADDR_MASK = ~((word_t'(1) << ADDR_LSB) - word_t'(1));

    exmem_state_t state_q, state_d;
    word_t        memload_q, memload_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            memload_q <= '0;
        end else begin
            state_q   <= state_d;
            memload_q <= memload_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        memload_d = memload_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            ACCESS: begin
                if (dhit) begin
                    state_d = IDLE;
                    // Only a pure load refreshes the buffer; stores leave it untouched.
                    if (req_dre && !req_dwe) memload_d = dmemload;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        memstall  = 1'b0;
        memready  = 1'b1;
        if (state_q == ACCESS) begin
            dmemREN   = req_dre & ~req_dwe;
            dmemWEN   = req_dwe;
            dmemaddr  = req_addr & ADDR_MASK;
            dmemstore = req_store;
            memstall  = 1'b1;
            memready  = 1'b0;
        end
    end

    assign memload = memload_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures EX results, drives the data cache
// through dmem_req_fsm. Optional forwarding outputs under EX_MEM_FWD_EN.
module ex_mem_stage
    import cpu_types_pkg::*;
#(
    parameter int ADDR_LSB = 2
) (
    input logic     CLK,
    input logic     RST,
    ex_mem_if.exmem bus
);

    exmem_bundle_t bundle_q, bundle_d;
    logic          capture, start, memstall, memready;

    always_ff @(posedge CLK) begin
        if (RST) bundle_q <= EXMEM_NOP;
        else     bundle_q <= bundle_d;
    end

    // Halt is sticky: once captured, capture stays blocked until reset.
    always_comb begin
        capture  = bus.exW & ~memstall & ~bundle_q.halt;
        bundle_d = bundle_q;
        if (capture) begin
            if (bus.exFLUSH) begin
                bundle_d = EXMEM_NOP;
            end else begin
                bundle_d.dre      = bus.excuDRE;
                bundle_d.dwe      = bus.excuDWE;
                bundle_d.memtoreg = bus.exMemToReg;
                bundle_d.wen      = bus.exWEN;
                bundle_d.halt     = bus.excuHALT;
                bundle_d.wsel     = bus.exwsel;
                bundle_d.aluout   = bus.exaluout;
                bundle_d.rdat2    = bus.exrdat2;
                bundle_d.instr    = bus.exinstr;
            end
        end
        start = capture & ~bus.exFLUSH & (bus.excuDRE | bus.excuDWE);
    end

    a_no_dre_dwe: assert property (@(posedge CLK) disable iff (RST)
        !(start && bus.excuDRE && bus.excuDWE));

    dmem_req_fsm #(.ADDR_LSB(ADDR_LSB)) u_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .req_dre   (bundle_q.dre),
        .req_dwe   (bundle_q.dwe),
        .req_addr  (bundle_q.aluout),
        .req_store (bundle_q.rdat2),
        .dhit      (bus.dhit),
        .dmemload  (bus.dmemload),
        .dmemREN   (bus.dmemREN),
        .dmemWEN   (bus.dmemWEN),
        .dmemaddr  (bus.dmemaddr),
        .dmemstore (bus.dmemstore),
        .memload   (bus.memload),
        .memstall  (memstall),
        .memready  (memready)
    );

    assign bus.memstall    = memstall;
    assign bus.memready    = memready;
    assign bus.memMemToReg = bundle_q.memtoreg;
    assign bus.memWEN      = bundle_q.wen;
    assign bus.memHALT     = bundle_q.halt;
    assign bus.memwsel     = bundle_q.wsel;
    assign bus.memaluout   = bundle_q.aluout;
    assign bus.meminstr    = bundle_q.instr;

`ifdef EX_MEM_FWD_EN
    assign bus.memfwd_en   = bundle_q.wen & ~bundle_q.memtoreg & memready & (bundle_q.wsel != '0);
    assign bus.memfwd_sel  = bundle_q.wsel;
    assign bus.memfwd_data = bundle_q.aluout;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, ALU, load, store,
// flush, back-to-back and halt scenarios.
module tb_ex_mem_stage;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    ex_mem_if bus ();

    ex_mem_stage #(.ADDR_LSB(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic w, input logic flush, input logic dre, input logic dwe,
                            input logic halt, input logic m2r, input logic wen, input logic [4:0] wsel,
                            input logic [31:0] alu, input logic [31:0] rdat2, input logic [31:0] instr);
        bus.exW        = w;
        bus.exFLUSH    = flush;
        bus.excuDRE    = dre;
        bus.excuDWE    = dwe;
        bus.excuHALT   = halt;
        bus.exMemToReg = m2r;
        bus.exWEN      = wen;
        bus.exwsel     = wsel;
        bus.exaluout   = alu;
        bus.exrdat2    = rdat2;
        bus.exinstr    = instr;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        // start a load, then reset in the middle of the access
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0100, 32'h0, 32'h8C00_0000);
        tick();
        idle_ex();
        n_checks++;
        if (bus.dmemREN !== 1'b1) begin n_fail++; $display("FAIL reset_pre_ren: got %0b expected 1", bus.dmemREN); end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("txn reset: ren=%0b stall=%0b ready=%0b", bus.dmemREN, bus.memstall, bus.memready);
        n_checks++;
        if (bus.dmemREN !== 1'b0 || bus.dmemWEN !== 1'b0) begin n_fail++; $display("FAIL reset_req: got ren=%0b wen=%0b expected 0/0", bus.dmemREN, bus.dmemWEN); end
        n_checks++;
        if (bus.memstall !== 1'b0 || bus.memready !== 1'b1) begin n_fail++; $display("FAIL reset_status: got stall=%0b ready=%0b expected 0/1", bus.memstall, bus.memready); end
        n_checks++;
        if (bus.memaluout !== 32'h0 || bus.memwsel !== 5'd0 || bus.memWEN !== 1'b0 || bus.memMemToReg !== 1'b0) begin
            n_fail++; $display("FAIL reset_bundle: got alu=%h wsel=%0d wen=%0b m2r=%0b expected zeros", bus.memaluout, bus.memwsel, bus.memWEN, bus.memMemToReg);
        end
        n_checks++;
        if (bus.memload !== 32'h0 || bus.memHALT !== 1'b0 || bus.dmemaddr !== 32'h0 || bus.meminstr !== 32'h0) begin
            n_fail++; $display("FAIL reset_misc: got load=%h halt=%0b addr=%h instr=%h expected zeros", bus.memload, bus.memHALT, bus.dmemaddr, bus.meminstr);
        end
    endtask

    task automatic test_alu_op();
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0000_0020);
        tick();
        idle_ex();
        $display("txn alu_op: wsel=%0d alu=%h ready=%0b", bus.memwsel, bus.memaluout, bus.memready);
        n_checks++;
        if (bus.memwsel !== 5'd5 || bus.memaluout !== 32'h0000_1234 || bus.memWEN !== 1'b1) begin
            n_fail++; $display("FAIL alu_bundle: got wsel=%0d alu=%h wen=%0b expected 5/00001234/1", bus.memwsel, bus.memaluout, bus.memWEN);
        end
        n_checks++;
        if (bus.memready !== 1'b1 || bus.memstall !== 1'b0 || bus.dmemREN !== 1'b0 || bus.dmemWEN !== 1'b0) begin
            n_fail++; $display("FAIL alu_status: got ready=%0b stall=%0b ren=%0b wen=%0b expected 1/0/0/0", bus.memready, bus.memstall, bus.dmemREN, bus.dmemWEN);
        end
`ifdef EX_MEM_FWD_EN
        n_checks++;
        if (bus.memfwd_en !== 1'b1 || bus.memfwd_sel !== 5'd5 || bus.memfwd_data !== 32'h0000_1234) begin
            n_fail++; $display("FAIL alu_fwd: got en=%0b sel=%0d data=%h expected 1/5/00001234", bus.memfwd_en, bus.memfwd_sel, bus.memfwd_data);
        end
`endif
    endtask

    task automatic test_load();
        bus.dmemload = 32'hDEAD_BEEF;
        bus.dhit     = 1'b0;
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0100, 32'h0, 32'h8C03_0100);
        tick();
        idle_ex();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.dmemREN !== 1'b1 || bus.dmemWEN !== 1'b0 || bus.dmemaddr !== 32'h0000_0100) begin
                n_fail++; $display("FAIL load_req[%0d]: got ren=%0b wen=%0b addr=%h expected 1/0/00000100", i, bus.dmemREN, bus.dmemWEN, bus.dmemaddr);
            end
            n_checks++;
            if (bus.memstall !== 1'b1 || bus.memready !== 1'b0) begin
                n_fail++; $display("FAIL load_stall[%0d]: got stall=%0b ready=%0b expected 1/0", i, bus.memstall, bus.memready);
            end
            if (i == 2) bus.dhit = 1'b1;
            tick();
        end
        bus.dhit = 1'b0;
        $display("txn load: addr=00000100 memload=%h ready=%0b", bus.memload, bus.memready);
        n_checks++;
        if (bus.memload !== 32'hDEAD_BEEF || bus.memready !== 1'b1 || bus.memstall !== 1'b0) begin
            n_fail++; $display("FAIL load_done: got load=%h ready=%0b stall=%0b expected deadbeef/1/0", bus.memload, bus.memready, bus.memstall);
        end
        n_checks++;
        if (bus.dmemREN !== 1'b0 || bus.memMemToReg !== 1'b1 || bus.memwsel !== 5'd3) begin
            n_fail++; $display("FAIL load_after: got ren=%0b m2r=%0b wsel=%0d expected 0/1/3", bus.dmemREN, bus.memMemToReg, bus.memwsel);
        end
`ifdef EX_MEM_FWD_EN
        n_checks++;
        if (bus.memfwd_en !== 1'b0) begin n_fail++; $display("FAIL load_fwd: got en=%0b expected 0", bus.memfwd_en); end
`endif
    endtask

    task automatic test_store_flush();
        bus.dmemload = 32'h1357_9BDF;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0203, 32'h0000_CAFE, 32'hAC00_0203);
        tick();
        // flush and a new op presented while the store is outstanding
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0999, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.dmemWEN !== 1'b1 || bus.dmemREN !== 1'b0 || bus.dmemaddr !== 32'h0000_0200 || bus.dmemstore !== 32'h0000_CAFE) begin
                n_fail++; $display("FAIL store_req[%0d]: got wen=%0b ren=%0b addr=%h data=%h expected 1/0/00000200/0000cafe", i, bus.dmemWEN, bus.dmemREN, bus.dmemaddr, bus.dmemstore);
            end
            n_checks++;
            if (bus.memaluout !== 32'h0000_0203 || bus.memWEN !== 1'b0 || bus.memstall !== 1'b1) begin
                n_fail++; $display("FAIL store_hold[%0d]: got alu=%h wen=%0b stall=%0b expected 00000203/0/1", i, bus.memaluout, bus.memWEN, bus.memstall);
            end
            tick();
        end
        idle_ex();
        bus.dhit = 1'b1;
        tick();
        bus.dhit = 1'b0;
        $display("txn store: addr=00000200 data=0000cafe ready=%0b", bus.memready);
        n_checks++;
        if (bus.dmemWEN !== 1'b0 || bus.memready !== 1'b1 || bus.memaluout !== 32'h0000_0203) begin
            n_fail++; $display("FAIL store_done: got wen=%0b ready=%0b alu=%h expected 0/1/00000203", bus.dmemWEN, bus.memready, bus.memaluout);
        end
        n_checks++;
        if (bus.memload !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_memload: got %h expected deadbeef", bus.memload); end
    endtask

    task automatic test_flush_capture();
        drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0044, 32'h0000_0055, 32'hAC07_0044);
        tick();
        idle_ex();
        $display("txn flush: wen=%0b wsel=%0d dmemWEN=%0b", bus.memWEN, bus.memwsel, bus.dmemWEN);
        n_checks++;
        if (bus.memWEN !== 1'b0 || bus.memwsel !== 5'd0 || bus.memaluout !== 32'h0 || bus.meminstr !== 32'h0) begin
            n_fail++; $display("FAIL flush_bundle: got wen=%0b wsel=%0d alu=%h instr=%h expected zeros", bus.memWEN, bus.memwsel, bus.memaluout, bus.meminstr);
        end
        n_checks++;
        if (bus.dmemWEN !== 1'b0 || bus.memstall !== 1'b0 || bus.memready !== 1'b1) begin
            n_fail++; $display("FAIL flush_req: got wen=%0b stall=%0b ready=%0b expected 0/0/1", bus.dmemWEN, bus.memstall, bus.memready);
        end
    endtask

    task automatic test_back_to_back();
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0011, 32'h0, 32'h0000_0001);
        tick();
        n_checks++;
        if (bus.memwsel !== 5'd1 || bus.memaluout !== 32'h0000_0011 || bus.meminstr !== 32'h0000_0001) begin
            n_fail++; $display("FAIL b2b_first: got wsel=%0d alu=%h instr=%h expected 1/00000011/00000001", bus.memwsel, bus.memaluout, bus.meminstr);
        end
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0022, 32'h0, 32'h0000_0002);
        tick();
        idle_ex();
        $display("txn back_to_back: wsel=%0d alu=%h", bus.memwsel, bus.memaluout);
        n_checks++;
        if (bus.memwsel !== 5'd2 || bus.memaluout !== 32'h0000_0022 || bus.memready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got wsel=%0d alu=%h ready=%0b expected 2/00000022/1", bus.memwsel, bus.memaluout, bus.memready);
        end
    endtask

    task automatic test_halt();
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 32'h0, 32'hFFFF_FFFF);
        tick();
        n_checks++;
        if (bus.memHALT !== 1'b1 || bus.memwsel !== 5'd9) begin
            n_fail++; $display("FAIL halt_set: got halt=%0b wsel=%0d expected 1/9", bus.memHALT, bus.memwsel);
        end
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0000_0020);
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h1111_1111;
        tick();
        tick();
        idle_ex();
        bus.dhit = 1'b0;
        $display("txn halt: halt=%0b alu=%h", bus.memHALT, bus.memaluout);
        n_checks++;
        if (bus.memHALT !== 1'b1 || bus.memaluout !== 32'h0000_0055 || bus.memwsel !== 5'd9) begin
            n_fail++; $display("FAIL halt_block: got halt=%0b alu=%h wsel=%0d expected 1/00000055/9", bus.memHALT, bus.memaluout, bus.memwsel);
        end
        n_checks++;
        if (bus.memload !== 32'hDEAD_BEEF || bus.dmemREN !== 1'b0) begin
            n_fail++; $display("FAIL idle_dhit: got load=%h ren=%0b expected deadbeef/0", bus.memload, bus.dmemREN);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.memHALT !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %0b expected 0", bus.memHALT); end
    endtask

    initial begin
        idle_ex();
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0;
        test_reset();
        test_alu_op();
        test_load();
        test_store_flush();
        test_flush_capture();
        test_back_to_back();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
